// File: rtl/edl_final_pwm_capture.sv
// Avalon-MM PWM capture: measures high time and period of pwm_in in clk cycles.
// Optional build macro PWM_CAPTURE_GLITCH_FILTER_EN adds a 3-sample glitch filter on the input.
`timescale 1ns/1ps
module edl_final_pwm_capture #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        pwm_in,
    output logic        irq
);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT_RISE, ST_HIGH, ST_LOW} state_t;

    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   sync_s;
    logic                   level_s;
    logic                   prev_r;
    logic                   rise_s;
    logic                   fall_s;
    logic                   wr_s;
    logic                   wr_ctrl_s;
    logic                   wr_status_s;
    logic                   en_r;
    logic                   irq_en_r;
    logic                   new_r;
    logic                   ovf_r;
    state_t                 state_r;
    logic [CNT_W-1:0]       cnt_r;
    logic [CNT_W-1:0]       high_lat_r;
    logic [CNT_W-1:0]       high_r;
    logic [CNT_W-1:0]       period_r;
    logic [31:0]            rdata_s;
    logic                   unused_s;

    assign sync_s      = sync_r[SYNC_STAGES-1];
    assign wr_s        = chipselect & ~write_n;
    assign wr_ctrl_s   = wr_s & (address == 2'd2);
    assign wr_status_s = wr_s & (address == 2'd3);
    assign unused_s    = ^writedata[31:2];

    // Metastability synchronizer for the asynchronous PWM input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], pwm_in};
        end
    end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    logic [1:0] hist_r;
    logic       filt_r;

    // Level follows the input only once three consecutive samples agree.
    always_comb begin
        if ((sync_s == hist_r[0]) && (sync_s == hist_r[1])) begin
            level_s = sync_s;
        end else begin
            level_s = filt_r;
        end
    end

    // Sample history and held filter level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist_r <= 2'b00;
            filt_r <= 1'b0;
        end else begin
            hist_r <= {hist_r[0], sync_s};
            filt_r <= level_s;
        end
    end
`else
    assign level_s = sync_s;
`endif

    assign rise_s = level_s & ~prev_r;
    assign fall_s = ~level_s & prev_r;

    // Previous-level flop for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_r <= 1'b0;
        end else begin
            prev_r <= level_s;
        end
    end

    // Control register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            en_r     <= 1'b0;
            irq_en_r <= 1'b0;
        end else if (wr_ctrl_s) begin
            en_r     <= writedata[0];
            irq_en_r <= writedata[1];
        end else begin
            en_r     <= en_r;
            irq_en_r <= irq_en_r;
        end
    end

    // Measurement FSM plus status flags; hardware sets are assigned last so they beat W1C.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= ST_IDLE;
            cnt_r      <= CNT_ZERO;
            high_lat_r <= CNT_ZERO;
            high_r     <= CNT_ZERO;
            period_r   <= CNT_ZERO;
            new_r      <= 1'b0;
            ovf_r      <= 1'b0;
        end else begin
            if (wr_status_s && writedata[0]) new_r <= 1'b0;
            if (wr_status_s && writedata[1]) ovf_r <= 1'b0;
            if (!en_r) begin
                state_r <= ST_IDLE;
                cnt_r   <= CNT_ZERO;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_WAIT_RISE;
                    end
                    ST_WAIT_RISE: begin
                        if (rise_s) begin
                            cnt_r   <= CNT_ONE;
                            state_r <= ST_HIGH;
                        end
                    end
                    ST_HIGH: begin
                        if (fall_s) begin
                            high_lat_r <= cnt_r;
                            cnt_r      <= cnt_r + CNT_ONE;
                            state_r    <= ST_LOW;
                        end else if (cnt_r == CNT_MAX) begin
                            ovf_r   <= 1'b1;
                            cnt_r   <= CNT_ZERO;
                            state_r <= ST_WAIT_RISE;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    ST_LOW: begin
                        if (rise_s) begin
                            high_r   <= high_lat_r;
                            period_r <= cnt_r;
                            new_r    <= 1'b1;
                            cnt_r    <= CNT_ONE;
                            state_r  <= ST_HIGH;
                        end else if (cnt_r == CNT_MAX) begin
                            ovf_r   <= 1'b1;
                            cnt_r   <= CNT_ZERO;
                            state_r <= ST_WAIT_RISE;
                        end else begin
                            cnt_r <= cnt_r + CNT_ONE;
                        end
                    end
                    default: begin
                        cnt_r   <= CNT_ZERO;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // Zero-wait-state read mux.
    always_comb begin
        rdata_s = 32'd0;
        case (address)
            2'd0:    rdata_s[CNT_W-1:0] = high_r;
            2'd1:    rdata_s[CNT_W-1:0] = period_r;
            2'd2:    rdata_s[1:0]       = {irq_en_r, en_r};
            2'd3:    rdata_s[1:0]       = {ovf_r, new_r};
            default: rdata_s            = 32'd0;
        endcase
    end

    assign readdata = rdata_s;
    assign irq      = new_r & irq_en_r;

endmodule

// File: tb/tb_edl_final_pwm_capture.sv
// Directed self-checking bench for edl_final_pwm_capture: register table plus hand-timed PWM sequences.
`timescale 1ns/1ps
module tb_edl_final_pwm_capture;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        pwm_in;
    logic        irq;

    int tests_run;
    int tests_failed;

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 3;
`endif
    localparam int WAITN = LAT + 2;

    typedef struct {
        bit          wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        bit          pwm;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[10];

    edl_final_pwm_capture #(.CNT_W(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .pwm_in     (pwm_in),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic read_chk(input logic [1:0] a, input string name, input logic [31:0] exp);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        #1;
        check(name, readdata, exp);
        chipselect = 1'b0;
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic pwm_phase(input bit lvl, input int n);
        pwm_in = lvl;
        tick(n);
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        reset_n      = 1'b0;
        address      = 2'd0;
        chipselect   = 1'b0;
        write_n      = 1'b1;
        writedata    = 32'd0;
        pwm_in       = 1'b0;

        vecs[0] = '{1'b0, 2'd0, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[1] = '{1'b0, 2'd1, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[2] = '{1'b0, 2'd2, 32'h0000_0000, 1'b1, 32'h0000_0000};
        vecs[3] = '{1'b0, 2'd3, 32'h0000_0000, 1'b0, 32'h0000_0000};
        vecs[4] = '{1'b1, 2'd2, 32'hFFFF_FFFC, 1'b1, 32'h0000_0000};
        vecs[5] = '{1'b1, 2'd2, 32'h0000_0002, 1'b0, 32'h0000_0002};
        vecs[6] = '{1'b1, 2'd0, 32'h0000_FFFF, 1'b1, 32'h0000_0000};
        vecs[7] = '{1'b1, 2'd3, 32'h0000_0003, 1'b0, 32'h0000_0000};
        vecs[8] = '{1'b1, 2'd1, 32'h0000_1234, 1'b1, 32'h0000_0000};
        vecs[9] = '{1'b1, 2'd2, 32'h0000_0000, 1'b0, 32'h0000_0000};

        // Reset state
        #1;
        read_chk(2'd0, "rst_high", 32'd0);
        read_chk(2'd1, "rst_period", 32'd0);
        read_chk(2'd2, "rst_ctrl", 32'd0);
        read_chk(2'd3, "rst_status", 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        tick(3);
        reset_n = 1'b1;
        tick(2);

        // Register table with PWM toggling while EN=0
        for (int i = 0; i < 10; i++) begin
            pwm_in = vecs[i].pwm;
            if (vecs[i].wr) bus_write(vecs[i].addr, vecs[i].wdata);
            else            tick(1);
            read_chk(vecs[i].addr, $sformatf("reg_vec%0d", i), vecs[i].exp);
        end
        for (int i = 0; i < 10; i++) pwm_phase(i[0], 3);
        read_chk(2'd3, "dis_status", 32'd0);
        read_chk(2'd0, "dis_high", 32'd0);
        check("dis_irq", {31'd0, irq}, 32'd0);

        // 30/70 PWM with EN and IRQ_EN
        pwm_phase(1'b0, 5);
        bus_write(2'd2, 32'd3);
        tick(2);
        pwm_phase(1'b1, 30);
        pwm_phase(1'b0, 70);
        read_chk(2'd3, "arm_no_sample", 32'd0);
        pwm_phase(1'b1, WAITN);
        read_chk(2'd0, "p30_high", 32'd30);
        read_chk(2'd1, "p30_period", 32'd100);
        read_chk(2'd3, "p30_status", 32'd1);
        check("p30_irq", {31'd0, irq}, 32'd1);
        bus_write(2'd3, 32'd1);
        read_chk(2'd3, "w1c_status", 32'd0);
        check("w1c_irq", {31'd0, irq}, 32'd0);
        tick(30 - WAITN - 1);
        pwm_phase(1'b0, 70);
        pwm_phase(1'b1, WAITN);
        read_chk(2'd3, "reset_new", 32'd1);
        read_chk(2'd0, "p30b_high", 32'd30);
        read_chk(2'd1, "p30b_period", 32'd100);

        // Constant high input overflows the counter
        tick(70000);
        read_chk(2'd3, "ovf_status", 32'd3);
        read_chk(2'd0, "ovf_high", 32'd30);
        read_chk(2'd1, "ovf_period", 32'd100);
        bus_write(2'd3, 32'd3);
        read_chk(2'd3, "ovf_clr", 32'd0);
        pwm_phase(1'b0, 10);
        pwm_phase(1'b1, 10);
        pwm_phase(1'b0, 10);
        pwm_phase(1'b1, WAITN);
        read_chk(2'd0, "p10_high", 32'd10);
        read_chk(2'd1, "p10_period", 32'd20);
        read_chk(2'd3, "p10_status", 32'd1);

        // EN cleared mid-high, re-enabled: interrupted period discarded
        bus_write(2'd3, 32'd1);
        bus_write(2'd2, 32'd2);
        bus_write(2'd2, 32'd3);
        tick(10 - WAITN - 3);
        pwm_phase(1'b0, 10);
        pwm_phase(1'b1, WAITN);
        read_chk(2'd3, "reen_status", 32'd0);
        read_chk(2'd0, "reen_old_high", 32'd10);
        read_chk(2'd1, "reen_old_period", 32'd20);
        tick(8 - WAITN);
        pwm_phase(1'b0, 16);
        pwm_phase(1'b1, WAITN);
        read_chk(2'd0, "p8_high", 32'd8);
        read_chk(2'd1, "p8_period", 32'd24);
        read_chk(2'd3, "p8_status", 32'd1);

        // W1C of NEW on the capture edge: set wins
        tick(8 - WAITN);
        pwm_phase(1'b0, 2);
        bus_write(2'd3, 32'd1);
        read_chk(2'd3, "pre_race_status", 32'd0);
        tick(13);
        pwm_in = 1'b1;
        tick(LAT - 1);
        bus_write(2'd3, 32'd1);
        read_chk(2'd3, "race_status", 32'd1);
        read_chk(2'd0, "race_high", 32'd8);
        read_chk(2'd1, "race_period", 32'd24);
        check("race_irq", {31'd0, irq}, 32'd1);

        // 2-cycle glitch inside the low phase of a 50/50 waveform
        bus_write(2'd2, 32'd0);
        pwm_phase(1'b0, 10);
        bus_write(2'd3, 32'd3);
        bus_write(2'd2, 32'd3);
        tick(2);
        pwm_phase(1'b1, 50);
        pwm_phase(1'b0, 20);
        pwm_phase(1'b1, 2);
        pwm_phase(1'b0, 28);
        pwm_phase(1'b1, WAITN);
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
        read_chk(2'd0, "glitch_high", 32'd50);
        read_chk(2'd1, "glitch_period", 32'd100);
`else
        read_chk(2'd0, "glitch_high", 32'd2);
        read_chk(2'd1, "glitch_period", 32'd30);
`endif
        read_chk(2'd3, "glitch_status", 32'd1);

        // Asynchronous reset mid-measurement
        tick(3);
        reset_n = 1'b0;
        #1;
        check("arst_irq", {31'd0, irq}, 32'd0);
        read_chk(2'd0, "arst_high", 32'd0);
        read_chk(2'd1, "arst_period", 32'd0);
        read_chk(2'd2, "arst_ctrl", 32'd0);
        read_chk(2'd3, "arst_status", 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
